decimal_to_bcd_encoder: RTL and testbench

//  Encodes ten active-high decimal key lines (digit 0..9) into a 4-bit BCD code.

---
 rtl/decimal_to_bcd_encoder.sv | 173 +++++++++++++++++
 tb/tb_decimal_to_bcd_encoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/decimal_to_bcd_encoder.sv
// ---------------------------------------------------------------------------
// decimal_to_bcd_encoder
//   Encodes ten active-high decimal key lines into a 4-bit BCD digit.
//   The raw keys pass through a 2-FF synchroniser and are then debounced on
//   press and on release. Each debounced press yields one code on a
//   valid/ready output.
//
//   Optional feature macro: MULTI_KEY_ERR_EN
//     defined   : adds key_err. When more than one key is held during the
//                 debounce window, key_err is set and no code is produced.
//     undefined : when several keys are held, the highest index wins.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles required for press and for release (>=1)
//   CNT_W            debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   key_in       in   [9:0] raw key lines, bit i = digit i, asynchronous
//   out_ready    in   downstream accepts the code when out_valid && out_ready
//   overrun_clr  in   synchronous clear of overrun (and of key_err)
//   bcd_out      out  [3:0] encoded digit 0..9
//   out_valid    out  bcd_out holds an unconsumed code
//   overrun      out  sticky: a press was dropped because the output was full
//   key_err      out  sticky multi-key error (MULTI_KEY_ERR_EN only)
//   busy         out  FSM is in any state other than IDLE
// ---------------------------------------------------------------------------
module decimal_to_bcd_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key_in,
    input  logic       out_ready,
    input  logic       overrun_clr,
    output logic [3:0] bcd_out,
    output logic       out_valid,
    output logic       overrun,
`ifdef MULTI_KEY_ERR_EN
    output logic       key_err,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [9:0]       key_meta_q;
    logic [9:0]       key_s_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       code_q;
    logic [3:0]       bcd_q;
    logic             valid_q;
    logic             overrun_q;
    logic [3:0]       enc_d;
    logic             any_d;
    logic             can_load_d;

    // 2-FF synchroniser for the asynchronous key lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= '0;
            key_s_q    <= '0;
        end else begin
            key_meta_q <= key_in;
            key_s_q    <= key_meta_q;
        end
    end

    // Priority encoder: the loop visits higher indices later, so the highest set bit wins
    always_comb begin
        enc_d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_s_q[i]) enc_d = 4'(i);
        end
    end

    assign any_d      = |key_s_q;
    // The output slot is free when it is empty or is being drained on this edge
    assign can_load_d = !valid_q || out_ready;

`ifdef MULTI_KEY_ERR_EN
    logic key_err_q;
    logic multi_d;
    // x & (x-1) is non-zero exactly when two or more bits are set
    assign multi_d = |(key_s_q & (key_s_q - 10'd1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            code_q    <= 4'd0;
            bcd_q     <= 4'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef MULTI_KEY_ERR_EN
            key_err_q <= 1'b0;
`endif
        end else begin
            // Handshake and sticky-clear defaults. An EMIT below overrides them,
            // so a reload beats the drain and a set beats the clear.
            if (valid_q && out_ready) valid_q <= 1'b0;
            if (overrun_clr) overrun_q <= 1'b0;
`ifdef MULTI_KEY_ERR_EN
            if (overrun_clr) key_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (any_d) begin
                        code_q  <= enc_d;
                        cnt_q   <= '0;
                        state_q <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!any_d || enc_d != code_q) begin
                        state_q <= ST_IDLE;
`ifdef MULTI_KEY_ERR_EN
                    end else if (multi_d) begin
                        key_err_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_WAIT_REL;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_EMIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (can_load_d) begin
                        bcd_q   <= code_q;
                        valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    // Any key activity restarts the release window; the digit is not re-read
                    if (any_d) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bcd_out   = bcd_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef MULTI_KEY_ERR_EN
    assign key_err   = key_err_q;
`endif

endmodule

// File: tb/tb_decimal_to_bcd_encoder.sv
module tb_decimal_to_bcd_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] key_in;
    logic       out_ready;
    logic       overrun_clr;
    logic [3:0] bcd_out;
    logic       out_valid;
    logic       overrun;
    logic       busy;
`ifdef MULTI_KEY_ERR_EN
    logic       key_err;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int ready_mode = 0;  // 0: hold out_ready, 1: toggle each cycle, 2: random (mostly high)

    decimal_to_bcd_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_in(key_in),
        .out_ready(out_ready),
        .overrun_clr(overrun_clr),
        .bcd_out(bcd_out),
        .out_valid(out_valid),
        .overrun(overrun),
`ifdef MULTI_KEY_ERR_EN
        .key_err(key_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the digit of a key vector is the index of its highest set bit
    function automatic int ref_digit(input logic [9:0] k);
        return $clog2(int'(k) + 1) - 1;
    endfunction

    // One clock. Inputs are final here, so the handshake the DUT is about to see
    // is scored now; then step to the falling edge.
    task automatic cyc();
        bit       hold_pend;
        bit [3:0] hold_bcd;
        if (out_valid && out_ready && rst_n) begin
            chk("sb_expect_pending", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("sb_code", int'(bcd_out), exp_q.pop_front());
        end
        hold_pend = out_valid && !out_ready && rst_n;
        hold_bcd  = bcd_out;
        @(negedge clk);
        if (hold_pend && rst_n) chk("hold_stable", int'(bcd_out), int'(hold_bcd));
        if (out_valid) chk("bcd_range", int'(bcd_out <= 4'd9), 1);
        case (ready_mode)
            1: out_ready = ~out_ready;
            2: out_ready = ($urandom_range(3) != 0);
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic press(input logic [9:0] k, input int hold, input int rel);
        key_in = k;
        idle(hold);
        key_in = '0;
        idle(rel);
    endtask

    initial begin
        rst_n = 1'b0; key_in = '0; out_ready = 1'b1; overrun_clr = 1'b0;
        idle(3);
        chk("rst_bcd", int'(bcd_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        idle(2);

        // 1: key 5 held 20 cycles, code appears after edge D+4, exactly once
        key_in = 10'b00_0010_0000;
        exp_q.push_back(5);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == D + 3) chk("t1_valid_early", int'(out_valid), 0);
            if (i == D + 4) begin
                chk("t1_valid", int'(out_valid), 1);
                chk("t1_bcd", int'(bcd_out), 5);
            end
            if (i == D + 6) chk("t1_single", int'(out_valid), 0);
        end
        key_in = '0;
        idle(12);
        chk("t1_drained", exp_q.size(), 0);

        // 2: 3-cycle glitch on key 7 is rejected
        press(10'b00_1000_0000, 3, 12);
        chk("t2_valid", int'(out_valid), 0);
        chk("t2_busy", int'(busy), 0);
        chk("t2_none", exp_q.size(), 0);

        // 3: second press while first code still held -> dropped, overrun
        out_ready = 1'b0;
        exp_q.push_back(3);
        press(10'b00_0000_1000, 10, 10);
        press(10'b01_0000_0000, 10, 10);
        chk("t3_bcd", int'(bcd_out), 3);
        chk("t3_valid", int'(out_valid), 1);
        chk("t3_overrun", int'(overrun), 1);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("t3_overrun_clr", int'(overrun), 0);
        out_ready = 1'b1;
        idle(2);
        chk("t3_consumed", int'(out_valid), 0);
        chk("t3_drained", exp_q.size(), 0);

        // 4: keys 2 and 9 together
`ifdef MULTI_KEY_ERR_EN
        press(10'b10_0000_0100, 12, 12);
        chk("t4_key_err", int'(key_err), 1);
        chk("t4_no_code", int'(out_valid), 0);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("t4_key_err_clr", int'(key_err), 0);
`else
        exp_q.push_back(ref_digit(10'b10_0000_0100));
        press(10'b10_0000_0100, 12, 12);
        chk("t4_drained", exp_q.size(), 0);
`endif

        // 5: reset in the middle of debounce with key 4 still held
        key_in = 10'b00_0001_0000;
        idle(4);
        chk("t5_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        idle(2);
        chk("t5_rst_valid", int'(out_valid), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_bcd", int'(bcd_out), 0);
        rst_n = 1'b1;
        exp_q.push_back(4);
        for (int i = 1; i <= D + 4; i++) begin
            cyc();
            if (i == D + 3) chk("t5_valid_early", int'(out_valid), 0);
        end
        chk("t5_valid", int'(out_valid), 1);
        chk("t5_bcd", int'(bcd_out), 4);
        key_in = '0;
        idle(12);
        chk("t5_drained", exp_q.size(), 0);

        // 6: sweep 0..9 with out_ready toggling
        ready_mode = 1;
        for (int d = 0; d < 10; d++) begin
            logic [9:0] k;
            k = 10'd1 << d;
            exp_q.push_back(d);
            press(k, 10, 10);
        end
        ready_mode = 0; out_ready = 1'b1;
        idle(4);
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_overrun", int'(overrun), 0);

        // Random presses and glitches against the reference
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            logic [9:0] k;
`ifdef MULTI_KEY_ERR_EN
            k = 10'd1 << $urandom_range(9);
`else
            k = 10'($urandom_range(1023, 1));
`endif
            if ($urandom_range(3) == 0) begin
                press(k, $urandom_range(3, 1), 10);
            end else begin
                exp_q.push_back(ref_digit(k));
                press(k, $urandom_range(14, 8), $urandom_range(14, 9));
            end
        end
        ready_mode = 0; out_ready = 1'b1;
        idle(4);
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_overrun", int'(overrun), 0);
        chk("rnd_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
